// File: rtl/ahb_async_sram_halfwidth_ctrl_pkg.sv
// rtl/ahb_async_sram_halfwidth_ctrl_pkg.sv - shared states, AHB encodings and size decode for the SRAM bridge
package ahb_sram_pkg;

    // Bridge sequencing: ACC0 is the first/only SRAM cycle, ACC1 the upper half of a word,
    // RESP is only reached when read data is registered (SRAM_RDATA_REG_EN).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    // Access width after folding hsize > 2 onto word.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Anything wider than a word is treated as a word access.
    function automatic size_t decode_size(input logic [2:0] hsize);
        case (hsize)
            HSIZE_BYTE: return SZ_BYTE;
            HSIZE_HALF: return SZ_HALF;
            default:    return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/ahb_async_sram_halfwidth_ctrl_if.sv
// rtl/ahb_async_sram_halfwidth_ctrl_if.sv - AHB-Lite slave-port signal bundle
interface ahb_async_sram_halfwidth_ctrl_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              hready_resp;
    logic              hready;
    logic              hresp;
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic [W_DATA-1:0] hwdata;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        input  hready_resp, hresp, hrdata
    );

    modport slave (
        input  hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        output hready_resp, hresp, hrdata
    );
endinterface

// File: rtl/ahb_async_sram_halfwidth_ctrl_iobuf.sv
// rtl/ahb_async_sram_halfwidth_ctrl_iobuf.sv - tristate driver for the SRAM data bus
module sram_dq_iobuf #(
    parameter int W = 16
) (
    input  logic         oe,
    input  logic [W-1:0] dout,
    output logic [W-1:0] din,
    inout  wire  [W-1:0] pad
);

    assign pad = oe ? dout : {W{1'bz}};
    assign din = pad;

endmodule

// File: rtl/ahb_async_sram_halfwidth_ctrl.sv
// rtl/ahb_async_sram_halfwidth_ctrl.sv - AHB-Lite slave to 16-bit async SRAM bridge; SRAM_RDATA_REG_EN registers read data
module ahb_async_sram_halfwidth_ctrl
    import ahb_sram_pkg::*;
#(
    parameter  int W_DATA      = 32,
    parameter  int W_ADDR      = 32,
    parameter  int DEPTH       = 32,
    localparam int W_SRAM_ADDR = $clog2(DEPTH),
    localparam int W_SRAM_DATA = W_DATA / 2
) (
    input  logic                            clk,
    input  logic                            rst,
    ahb_async_sram_halfwidth_ctrl_if.slave  ahbls,
    output logic [W_SRAM_ADDR-1:0]          sram_addr,
    inout  wire  [W_SRAM_DATA-1:0]          sram_dq,
    output logic                            sram_ce_n,
    output logic                            sram_we_n,
    output logic                            sram_oe_n,
    output logic [1:0]                      sram_byte_n
);

    state_t                 state;
    logic                   hready_q;
    logic                   lat_write;
    size_t                  lat_size;
    logic [1:0]             lat_lane;
    logic [W_SRAM_DATA-1:0] rd_lo;
    logic [W_SRAM_DATA-1:0] dq_out;
    logic [W_SRAM_DATA-1:0] dq_in;
    logic [7:0]             wr_byte;

    logic                   accept;
    size_t                  a_size;
    logic [W_SRAM_ADDR-1:0] a_idx;
    logic [1:0]             a_byte_n;
    logic                   a_hready;

`ifdef SRAM_RDATA_REG_EN
    logic [W_DATA-1:0]      rdata_q;
`else
    logic [W_DATA-1:0]      hrdata_c;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{ahbls.haddr[W_ADDR-1:W_SRAM_ADDR+1], ahbls.htrans[0],
                             ahbls.hburst, ahbls.hprot, ahbls.hmastlock};

    assign accept = ahbls.hready && ahbls.htrans[1];
    assign a_size = decode_size(ahbls.hsize);

    // Address-phase decode: SRAM halfword index, lane enables and whether the access stalls.
    always_comb begin
        a_idx = ahbls.haddr[W_SRAM_ADDR:1];
        if (a_size == SZ_WORD) begin
            a_idx[0] = 1'b0;
        end
        a_byte_n = 2'b00;
        if (a_size == SZ_BYTE) begin
            a_byte_n = ahbls.haddr[0] ? 2'b01 : 2'b10;
        end
`ifdef SRAM_RDATA_REG_EN
        a_hready = (a_size != SZ_WORD) && ahbls.hwrite;
`else
        a_hready = (a_size != SZ_WORD);
`endif
    end

    // Access sequencer: SRAM strobes and HREADYOUT are registered so the pins change only at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hready_q    <= 1'b1;
            sram_addr   <= '0;
            sram_byte_n <= 2'b11;
            sram_ce_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            lat_write   <= 1'b0;
            lat_size    <= SZ_BYTE;
            lat_lane    <= 2'b00;
            rd_lo       <= '0;
`ifdef SRAM_RDATA_REG_EN
            rdata_q     <= '0;
`endif
        end else if (hready_q) begin
            // Last cycle of a data phase (or idle): the next address phase is sampled here.
            if (accept) begin
                state       <= ACC0;
                hready_q    <= a_hready;
                sram_addr   <= a_idx;
                sram_byte_n <= a_byte_n;
                sram_ce_n   <= 1'b0;
                sram_we_n   <= !ahbls.hwrite;
                sram_oe_n   <= ahbls.hwrite;
                lat_write   <= ahbls.hwrite;
                lat_size    <= a_size;
                lat_lane    <= ahbls.haddr[1:0];
            end else begin
                state       <= IDLE;
                hready_q    <= 1'b1;
                sram_byte_n <= 2'b11;
                sram_ce_n   <= 1'b1;
                sram_we_n   <= 1'b1;
                sram_oe_n   <= 1'b1;
            end
        end else begin
            case (state)
                ACC0: begin
                    if (lat_size == SZ_WORD) begin
                        // Low half done; keep strobes and move to the upper halfword.
                        state     <= ACC1;
                        sram_addr <= sram_addr + 1'b1;
                        rd_lo     <= dq_in;
`ifdef SRAM_RDATA_REG_EN
                        hready_q  <= lat_write;
`else
                        hready_q  <= 1'b1;
`endif
                    end else begin
`ifdef SRAM_RDATA_REG_EN
                        state     <= RESP;
                        rdata_q   <= {dq_in, dq_in};
`else
                        state     <= IDLE;
`endif
                        hready_q    <= 1'b1;
                        sram_byte_n <= 2'b11;
                        sram_ce_n   <= 1'b1;
                        sram_we_n   <= 1'b1;
                        sram_oe_n   <= 1'b1;
                    end
                end
`ifdef SRAM_RDATA_REG_EN
                ACC1: begin
                    state       <= RESP;
                    rdata_q     <= {dq_in, rd_lo};
                    hready_q    <= 1'b1;
                    sram_byte_n <= 2'b11;
                    sram_ce_n   <= 1'b1;
                    sram_we_n   <= 1'b1;
                    sram_oe_n   <= 1'b1;
                end
`endif
                default: begin
                    state       <= IDLE;
                    hready_q    <= 1'b1;
                    sram_byte_n <= 2'b11;
                    sram_ce_n   <= 1'b1;
                    sram_we_n   <= 1'b1;
                    sram_oe_n   <= 1'b1;
                end
            endcase
        end
    end

    // Write data steering from the AHB data phase onto the 16-bit SRAM bus.
    always_comb begin
        wr_byte = 8'(ahbls.hwdata >> {lat_lane, 3'b000});
        case (lat_size)
            SZ_WORD: dq_out = (state == ACC1) ? ahbls.hwdata[W_DATA-1:W_SRAM_DATA]
                                              : ahbls.hwdata[W_SRAM_DATA-1:0];
            SZ_HALF: dq_out = lat_lane[1] ? ahbls.hwdata[W_DATA-1:W_SRAM_DATA]
                                          : ahbls.hwdata[W_SRAM_DATA-1:0];
            default: dq_out = {wr_byte, wr_byte};
        endcase
    end

    // The bus is driven exactly while a write strobe is active, so reset or a turnaround releases it at the edge.
    sram_dq_iobuf #(
        .W (W_SRAM_DATA)
    ) u_dq_iobuf (
        .oe   (!sram_we_n),
        .dout (dq_out),
        .din  (dq_in),
        .pad  (sram_dq)
    );

`ifdef SRAM_RDATA_REG_EN
    assign ahbls.hrdata = rdata_q;
`else
    // Read return: narrow reads mirror dq into both halves so any byte/halfword lands in its AHB lane.
    always_comb begin
        hrdata_c = '0;
        if (!lat_write) begin
            if (state == ACC1) begin
                hrdata_c = {dq_in, rd_lo};
            end else if ((state == ACC0) && (lat_size != SZ_WORD)) begin
                hrdata_c = {dq_in, dq_in};
            end
        end
    end

    assign ahbls.hrdata = hrdata_c;
`endif

    assign ahbls.hready_resp = hready_q;
    assign ahbls.hresp       = 1'b0;

endmodule

// File: tb/tb_ahb_async_sram_halfwidth_ctrl.sv
// tb/tb_ahb_async_sram_halfwidth_ctrl.sv - self-checking bench with SRAM model and byte-level reference memory
module tb_ahb_async_sram_halfwidth_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NBYTE = 2 * DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_async_sram_halfwidth_ctrl_if bus ();
    assign bus.hready = bus.hready_resp;

    logic [AW-1:0] sram_addr;
    wire  [15:0]   sram_dq;
    logic          sram_ce_n;
    logic          sram_we_n;
    logic          sram_oe_n;
    logic [1:0]    sram_byte_n;

    ahb_async_sram_halfwidth_ctrl #(
        .W_DATA (32),
        .W_ADDR (32),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ahbls       (bus),
        .sram_addr   (sram_addr),
        .sram_dq     (sram_dq),
        .sram_ce_n   (sram_ce_n),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n),
        .sram_byte_n (sram_byte_n)
    );

    // Behavioural asynchronous SRAM: reads while ce/oe low, lane writes sampled mid-cycle.
    logic [15:0] mem [DEPTH];
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'bz;
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_byte_n[0]) mem[sram_addr][7:0]  <= sram_dq[7:0];
            if (!sram_byte_n[1]) mem[sram_addr][15:8] <= sram_dq[15:8];
        end
    end

    // Reference: AHB byte-addressed memory; byte at address a lives in lane a%4.
    logic [7:0] ref_mem [NBYTE];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] size);
        return (size >= 3'd2) ? 4 : (1 << size);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [2:0] size, input logic [31:0] wd);
        int n;
        int base;
        n = nbytes(size);
        base = int'(a) % NBYTE;
        base = base - (base % n);
        for (int i = 0; i < n; i++) begin
            ref_mem[base + i] = wd[8 * ((base + i) % 4) +: 8];
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] w;
        int base;
        base = int'(a) % NBYTE;
        base = base - (base % 4);
        for (int l = 0; l < 4; l++) w[8 * l +: 8] = ref_mem[base + l];
        return w;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [31:0] a, input logic [2:0] size);
        int n;
        logic [31:0] m;
        n = nbytes(size);
        m = (n == 4) ? 32'hFFFF_FFFF : (n == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
        return m << (8 * ((int'(a) % 4) - (int'(a) % n)));
    endfunction

    // One AHB transfer with an idle cycle before it; returns read data, wait states and the lane strobes seen.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] size,
                        input logic [31:0] wd, output logic [31:0] rd, output int waits,
                        output logic [1:0] bn);
        @(posedge clk); #1;
        bus.htrans = 2'b10;
        bus.haddr  = a;
        bus.hwrite = wr;
        bus.hsize  = size;
        @(posedge clk); #1;
        bus.htrans = 2'b00;
        bus.hwdata = wd;
        waits = 0;
        @(negedge clk);
        while (bus.hready_resp !== 1'b1 && waits < 8) begin
            waits++;
            @(negedge clk);
        end
        rd = bus.hrdata;
        bn = sram_byte_n;
        #1;
    endtask

    task automatic sweep(input string tag);
        for (int h = 0; h < DEPTH; h++) begin
            chk($sformatf("%s_hw%0d", tag, h), {16'h0, mem[h]}, {16'h0, ref_mem[2*h+1], ref_mem[2*h]});
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] wd;
        logic [31:0] words [16];
        logic [1:0]  bn;
        int          waits;
        int          contention;
        int          done;
        int          cycles;

        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0;
        for (int i = 0; i < NBYTE; i++) ref_mem[i] = 8'h0;
        bus.htrans = 2'b00; bus.haddr = '0; bus.hwrite = 1'b0; bus.hsize = 3'd0;
        bus.hwdata = '0; bus.hburst = 3'd0; bus.hprot = 4'd0; bus.hmastlock = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hready", {31'h0, bus.hready_resp}, 32'h1);
        chk("rst_hresp",  {31'h0, bus.hresp},       32'h0);
        chk("rst_ce_n",   {31'h0, sram_ce_n},       32'h1);
        chk("rst_we_n",   {31'h0, sram_we_n},       32'h1);
        chk("rst_oe_n",   {31'h0, sram_oe_n},       32'h1);
        chk("rst_byte_n", {30'h0, sram_byte_n},     32'h3);
        chk("rst_hrdata", bus.hrdata,               32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 16 random words across the whole SRAM, then read back
        for (int i = 0; i < 16; i++) begin
            words[i] = $urandom;
            xfer(1'b1, 32'(i * 4), 3'd2, words[i], rd, waits, bn);
            ref_write(32'(i * 4), 3'd2, words[i]);
            chk($sformatf("wr_word_wait%0d", i), 32'(waits), 32'd1);
        end
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 32'(i * 4), 3'd2, 32'h0, rd, waits, bn);
            chk($sformatf("rd_word%0d", i), rd, words[i]);
            chk($sformatf("rd_word_wait%0d", i), 32'(waits), 32'd1);
        end
        sweep("words");

        // Word split into low then high halfword
        xfer(1'b1, 32'h04, 3'd2, 32'hDEAD_BEEF, rd, waits, bn);
        ref_write(32'h04, 3'd2, 32'hDEAD_BEEF);
        chk("beef_hw2", {16'h0, mem[2]}, 32'h0000_BEEF);
        chk("dead_hw3", {16'h0, mem[3]}, 32'h0000_DEAD);
        xfer(1'b0, 32'h04, 3'd2, 32'h0, rd, waits, bn);
        chk("deadbeef_rd", rd, 32'hDEAD_BEEF);

        // Halfword in the upper AHB lane
        xfer(1'b1, 32'h06, 3'd1, 32'h1234_0000, rd, waits, bn);
        ref_write(32'h06, 3'd1, 32'h1234_0000);
        chk("half_byte_n", {30'h0, bn}, 32'h0);
        chk("half_wr_wait", 32'(waits), 32'd0);
        chk("half_hw3", {16'h0, mem[3]}, 32'h0000_1234);
        xfer(1'b0, 32'h06, 3'd1, 32'h0, rd, waits, bn);
        chk("half_rd", {16'h0, rd[31:16]}, 32'h0000_1234);
        chk("half_rd_wait", 32'(waits), 32'd0);

        // Byte in lane 3 -> upper SRAM byte of halfword 1
        xfer(1'b1, 32'h03, 3'd0, 32'hA500_0000, rd, waits, bn);
        ref_write(32'h03, 3'd0, 32'hA500_0000);
        chk("byte_byte_n", {30'h0, bn}, 32'h1);
        chk("byte_hi", {24'h0, mem[1][15:8]}, 32'h0000_00A5);
        chk("byte_lo_kept", {24'h0, mem[1][7:0]}, {24'h0, ref_mem[2]});
        xfer(1'b0, 32'h03, 3'd0, 32'h0, rd, waits, bn);
        chk("byte_rd", {24'h0, rd[31:24]}, 32'h0000_00A5);
        chk("byte_rd_wait", 32'(waits), 32'd0);

        // hsize above word behaves as word
        xfer(1'b0, 32'h08, 3'd3, 32'h0, rd, waits, bn);
        chk("hsize3_rd", rd, exp_word(32'h08));
        chk("hsize3_wait", 32'(waits), 32'd1);

        // BUSY transfer: zero-wait, no SRAM cycle
        @(posedge clk); #1;
        bus.htrans = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk("busy_ce_n", {31'h0, sram_ce_n}, 32'h1);
        chk("busy_hready", {31'h0, bus.hready_resp}, 32'h1);
        @(posedge clk); #1;
        bus.htrans = 2'b00;

        // Back-to-back word write then word read at 0x00, no idle gap
        wd = $urandom;
        @(posedge clk); #1;
        bus.htrans = 2'b10; bus.haddr = 32'h0; bus.hwrite = 1'b1; bus.hsize = 3'd2;
        @(posedge clk); #1;
        bus.hwdata = wd; bus.hwrite = 1'b0;
        contention = 0; done = 0; cycles = 0; rd = '0;
        for (int c = 0; c < 12 && done < 2; c++) begin
            @(negedge clk);
            cycles++;
            if (!sram_oe_n && !sram_we_n) contention++;
            if (bus.hready_resp === 1'b1) begin
                done++;
                if (done == 2) rd = bus.hrdata;
            end
            if (done < 2) begin
                @(posedge clk); #1;
                if (done == 1) bus.htrans = 2'b00;
            end
        end
        ref_write(32'h0, 3'd2, wd);
        chk("b2b_done", 32'(done), 32'd2);
        chk("b2b_cycles", 32'(cycles), 32'd4);
        chk("b2b_rd", rd, wd);
        chk("b2b_contention", 32'(contention), 32'd0);

        // Reset during ACC0 of a word write: abandoned, no SRAM write
        @(posedge clk); #1;
        bus.htrans = 2'b10; bus.haddr = 32'h10; bus.hwrite = 1'b1; bus.hsize = 3'd2;
        @(posedge clk); #1;
        bus.htrans = 2'b00; bus.hwdata = ~exp_word(32'h10);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ce_n", {31'h0, sram_ce_n}, 32'h1);
        chk("mid_rst_we_n", {31'h0, sram_we_n}, 32'h1);
        chk("mid_rst_hready", {31'h0, bus.hready_resp}, 32'h1);
        chk("mid_rst_byte_n", {30'h0, sram_byte_n}, 32'h3);
        chk("mid_rst_hrdata", bus.hrdata, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_hw8", {16'h0, mem[8]}, {16'h0, ref_mem[17], ref_mem[16]});
        chk("mid_rst_hw9", {16'h0, mem[9]}, {16'h0, ref_mem[19], ref_mem[18]});
        wd = $urandom;
        xfer(1'b1, 32'h10, 3'd2, wd, rd, waits, bn);
        ref_write(32'h10, 3'd2, wd);
        chk("post_rst_wr_wait", 32'(waits), 32'd1);
        xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, waits, bn);
        chk("post_rst_rd", rd, wd);

        // Randomized mixed traffic, addresses beyond 2*DEPTH wrap
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  sz;
            logic [31:0] a;
            logic        w;
            int          n;
            sz = 3'($urandom_range(0, 2));
            n  = nbytes(sz);
            a  = ($urandom_range(0, 255) / n) * n;
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            xfer(w, a, sz, wd, rd, waits, bn);
            chk($sformatf("rnd%0d_wait", i), 32'(waits), (n == 4) ? 32'd1 : 32'd0);
            if (w) begin
                ref_write(a, sz, wd);
                chk($sformatf("rnd%0d_byte_n", i), {30'h0, bn},
                    (n == 1) ? (a[0] ? 32'h1 : 32'h2) : 32'h0);
            end else begin
                chk($sformatf("rnd%0d_rd", i), rd & lane_mask(a, sz), exp_word(a) & lane_mask(a, sz));
            end
        end
        sweep("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_async_sram_halfwidth_ctrl.md
Name: ahb_async_sram_halfwidth_ctrl

Overview:
AHB-Lite slave bridging a 32-bit system bus onto an external asynchronous SRAM with a 16-bit data bus and active-low byte enables. Word accesses are split into two consecutive halfword SRAM cycles (low half first). Halfword and byte accesses use a single SRAM cycle. Sits on the AHB-Lite fabric as a memory slave in front of an off-chip SRAM.

Parameters:
W_DATA, 32, AHB data width; only 32 is supported.
W_ADDR, 32, AHB address width.
DEPTH, 32, SRAM depth in 16-bit halfwords; must be a power of 2.
W_SRAM_ADDR, $clog2(DEPTH), SRAM address width (derived localparam).
W_SRAM_DATA, W_DATA/2, SRAM data width (derived localparam, 16).

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
ahbls_hready_resp  out  1  slave HREADYOUT.
ahbls_hready  in  1  bus HREADY.
ahbls_hresp  out  1  always 0 (OKAY).
ahbls_haddr  in  W_ADDR  byte address.
ahbls_hwrite  in  1  1 = write.
ahbls_htrans  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
ahbls_hsize  in  3  0 = byte, 1 = halfword, 2 = word.
ahbls_hburst, ahbls_hprot, ahbls_hmastlock  in  3/4/1  ignored.
ahbls_hwdata  in  W_DATA  write data (data phase).
ahbls_hrdata  out  W_DATA  read data.
sram_addr  out  W_SRAM_ADDR  halfword address.
sram_dq  inout  16  bidirectional data.
sram_ce_n, sram_we_n, sram_oe_n  out  1  active-low chip/write/output enables.
sram_byte_n  out  2  active-low lane enables; bit 0 = dq[7:0].

Behaviour:
- Address phase is accepted when hready && htrans[1]. Latch haddr, hwrite and hsize.
- Halfword index = haddr[W_SRAM_ADDR:1]. Bits above this index are ignored, so addresses wrap modulo 2*DEPTH bytes.
- States: IDLE, ACC0 (first or only SRAM cycle), ACC1 (second halfword of a word access).
- Word access: ACC0 uses addr = {haddr[hi:2],0} with both lanes; ACC1 uses addr+1 with both lanes.
  - hready_resp is 0 during ACC0 and 1 during ACC1, giving 1 wait state.
- Halfword/byte access: ACC0 only, hready_resp = 1, zero wait states.
  - Halfword enables both lanes.
  - Byte enables only lane haddr[0].
- Write: sram_we_n = 0 for the whole access cycle. dq is driven only in write cycles; otherwise hi-Z.
  - Word: ACC0 drives hwdata[15:0], ACC1 drives hwdata[31:16].
  - Halfword: drives hwdata[16*haddr[1] +: 16].
  - Byte: drives the byte at hwdata[8*haddr[1:0] +: 8] on both dq lanes.
- Read: sram_oe_n = 0 during the access cycle.
  - Word: ACC0 captures dq into a 16-bit register; ACC1 returns hrdata = {dq, reg}.
  - Narrow: hrdata = {dq, dq} combinationally, so the addressed byte/halfword appears in its AHB lane.
- sram_ce_n = 0 in ACC0/ACC1 only. Idle: ce_n = oe_n = we_n = 1, byte_n = 2'b11, dq = Z.
- Pipelining: a new address phase is sampled in the last data-phase cycle, so back-to-back accesses have no idle gap. Write followed by read is legal; dq turns around at the edge.
- hsize > 2 is treated as word.
- IDLE/BUSY htrans produces a zero-wait OKAY with no SRAM activity.
- Reset (async, any time, including mid-word): state = IDLE, hready_resp = 1, all SRAM strobes deasserted, dq = Z, hrdata = 0. An interrupted access is abandoned.

Optional Feature:
- SRAM_RDATA_REG_EN defined: all read data is registered. Narrow reads gain 1 wait state; word reads return from the register after ACC1, giving 2 wait states. Eases the hrdata timing path.
- Undefined: combinational read path as specified above.

Decomposition:
- Package ahb_sram_pkg holds:
  - the state enum (IDLE/ACC0/ACC1);
  - HTRANS_IDLE/NONSEQ constants;
  - HSIZE_BYTE/HALF/WORD constants.
- One natural sub-module: sram_dq_iobuf (tristate driver with output-enable). The behavioural async SRAM model lives in the verification tree, not in the RTL.

Test Plan:
- Word write of 16 random words at 0x00..0x3C, then read back -> exact match. Each access shows exactly one hready_resp=0 cycle.
- Word write 0xDEADBEEF @0x04 -> SRAM halfword 2 = 0xBEEF, halfword 3 = 0xDEAD; read @0x04 returns 0xDEADBEEF.
- Halfword write 0x1234 @0x06 -> SRAM halfword 3 = 0x1234 with byte_n = 00; read @0x06 -> hrdata[31:16] = 0x1234 with zero wait.
- Byte write 0xA5 @0x03 -> only byte_n[1] = 0, halfword 1 upper byte = 0xA5, lower byte unchanged; read @0x03 -> hrdata[31:24] = 0xA5.
- Back-to-back write @0x00 then read @0x00 with no idle cycle -> read returns the new data; dq never driven during oe_n = 0.
- Assert rst during ACC0 of a word write -> outputs return to idle values immediately; the next word access completes normally.
